// File: rtl/modbus_frame_tx.sv
// modbus_frame_tx -- Modbus RTU frame transmitter for the slave datapath.
//
// Buffers up to MAX_LEN payload bytes, folds each accepted byte into a
// CRC-16/MODBUS, then feeds payload + CRC (low byte first) to uart_byte_tx
// one byte per tx_start/tx_done handshake. After the last byte it holds off
// for the 3.5-character silent interval before the next frame is accepted.
//
// Ports:
//   clk_in      system clock
//   rst_in      synchronous active-high reset
//   wr_en       payload byte write strobe (accepted in IDLE with room left)
//   wr_data     payload byte
//   send        start the buffered frame (level, acted on in IDLE only)
//   tx_done     one-cycle done pulse from uart_byte_tx
//   tx_start    one-cycle start pulse to uart_byte_tx
//   tx_data     byte to uart_byte_tx, stable from tx_start until tx_done
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse on the last cycle of the silent interval
//   wr_err      one-cycle pulse, cycle after a dropped write
//   byte_cnt    payload bytes currently buffered
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting writes, waiting for send with a non-empty frame
// START | tx_start pulse for the byte latched in tx_data
// WAIT  | byte in flight, waiting for tx_done
// GAP   | silent-interval down-counter, frame_done on terminal count

module modbus_frame_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LEN   = 8,
  parameter int CRC_EN    = 1,
  localparam int CNT_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             send,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             frame_done,
  output logic             wr_err,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int GAP_CYC = BIT_CYC * 77 / 2;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         buf_mem [MAX_LEN];
  logic [CNT_W-1:0]   byte_cnt_r;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        crc;
  logic [1:0]         crc_ph;     // 0 payload, 1 CRC low in flight, 2 CRC high in flight
  logic [7:0]         tx_data_r;
  logic [GAP_W-1:0]   gap_cnt;
  logic               wr_err_r;

  logic               wr_ok;
  logic [CNT_W-1:0]   idx_inc;
  logic               more;
  logic               crc_left;
  logic               gap_tc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign wr_ok    = wr_en && (state == S_IDLE) && (byte_cnt_r < CNT_W'(MAX_LEN));
  assign idx_inc  = CNT_W'(idx) + CNT_W'(1);
  assign more     = idx_inc < byte_cnt_r;
  assign crc_left = (CRC_EN != 0) && (crc_ph != 2'd2);
  assign gap_tc   = (gap_cnt == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (send && ((byte_cnt_r != '0) || wr_ok)) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (tx_done) state_nxt = (more || crc_left) ? S_START : S_GAP;
      S_GAP:   if (gap_tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload storage carries no reset; byte_cnt alone defines what is valid.
  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      buf_mem[byte_cnt_r[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_cnt_r <= '0;
      idx        <= '0;
      crc        <= 16'hFFFF;
      crc_ph     <= 2'd0;
      tx_data_r  <= 8'h00;
      gap_cnt    <= '0;
      wr_err_r   <= 1'b0;
    end else begin
      wr_err_r <= wr_en && !wr_ok;
      if (wr_ok) begin
        byte_cnt_r <= byte_cnt_r + CNT_W'(1);
        crc        <= crc_byte(crc, wr_data);
      end
      case (state)
        S_IDLE: begin
          if (state_nxt == S_START) begin
            idx    <= '0;
            crc_ph <= 2'd0;
            // An empty buffer means the first byte is arriving this very cycle.
            tx_data_r <= (byte_cnt_r == '0) ? wr_data : buf_mem[0];
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (more) begin
              idx       <= idx_inc[IDX_W-1:0];
              tx_data_r <= buf_mem[idx_inc[IDX_W-1:0]];
            end else if (crc_left && (crc_ph == 2'd0)) begin
              tx_data_r <= crc[7:0];
              crc_ph    <= 2'd1;
            end else if (crc_left) begin
              tx_data_r <= crc[15:8];
              crc_ph    <= 2'd2;
            end else begin
              gap_cnt <= GAP_W'(GAP_CYC - 1);
            end
          end
        end
        S_GAP: begin
          if (gap_tc) begin
            byte_cnt_r <= '0;
            idx        <= '0;
            crc        <= 16'hFFFF;
            crc_ph     <= 2'd0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_start   = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_GAP) && gap_tc;
  assign tx_data    = tx_data_r;
  assign wr_err     = wr_err_r;
  assign byte_cnt   = byte_cnt_r;

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Bench for modbus_frame_tx. Four instances share one stimulus bus and one
// UART responder; 'sel' routes strobes to one instance and picks its outputs.
//   0: 50 MHz / 115200, MAX_LEN 8, CRC on   (gap 16709)
//   1: 1 kHz / 100,     MAX_LEN 8, CRC on   (gap 385)
//   2: 1 kHz / 100,     MAX_LEN 4, CRC on   (gap 385)
//   3: 1 kHz / 100,     MAX_LEN 8, CRC off  (gap 385)

module tb_modbus_frame_tx;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       send;
  logic       tx_done;
  int         sel;
  int         lat;

  logic       wr_en_v [4];
  logic       send_v  [4];
  logic       done_v  [4];
  logic       ts [4];
  logic [7:0] td [4];
  logic       bz [4];
  logic       fd [4];
  logic       we [4];
  logic [3:0] bc0, bc1, bc3;
  logic [2:0] bc2;
  logic [3:0] bcv [4];

  logic       cur_start, cur_busy, cur_fd, cur_werr;
  logic [7:0] cur_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int werr_cnt  = 0;
  int stable_err = 0;
  int pulse_err  = 0;
  int last_done_edge = 0;
  int gap_of [4];
  logic [7:0] captured [$];

  for (genvar k = 0; k < 4; k++) begin : g_sel
    assign wr_en_v[k] = wr_en   && (sel == k);
    assign send_v[k]  = send    && (sel == k);
    assign done_v[k]  = tx_done && (sel == k);
  end

  assign bcv[0] = bc0;
  assign bcv[1] = bc1;
  assign bcv[2] = {1'b0, bc2};
  assign bcv[3] = bc3;

  assign cur_start = ts[sel];
  assign cur_data  = td[sel];
  assign cur_busy  = bz[sel];
  assign cur_fd    = fd[sel];
  assign cur_werr  = we[sel];

  modbus_frame_tx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .MAX_LEN(8), .CRC_EN(1)) d0 (
    .clk_in(clk), .rst_in(rst), .wr_en(wr_en_v[0]), .wr_data(wr_data), .send(send_v[0]),
    .tx_done(done_v[0]), .tx_start(ts[0]), .tx_data(td[0]), .busy(bz[0]),
    .frame_done(fd[0]), .wr_err(we[0]), .byte_cnt(bc0));

  modbus_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .MAX_LEN(8), .CRC_EN(1)) d1 (
    .clk_in(clk), .rst_in(rst), .wr_en(wr_en_v[1]), .wr_data(wr_data), .send(send_v[1]),
    .tx_done(done_v[1]), .tx_start(ts[1]), .tx_data(td[1]), .busy(bz[1]),
    .frame_done(fd[1]), .wr_err(we[1]), .byte_cnt(bc1));

  modbus_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .MAX_LEN(4), .CRC_EN(1)) d2 (
    .clk_in(clk), .rst_in(rst), .wr_en(wr_en_v[2]), .wr_data(wr_data), .send(send_v[2]),
    .tx_done(done_v[2]), .tx_start(ts[2]), .tx_data(td[2]), .busy(bz[2]),
    .frame_done(fd[2]), .wr_err(we[2]), .byte_cnt(bc2));

  modbus_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .MAX_LEN(8), .CRC_EN(0)) d3 (
    .clk_in(clk), .rst_in(rst), .wr_en(wr_en_v[3]), .wr_data(wr_data), .send(send_v[3]),
    .tx_done(done_v[3]), .tx_start(ts[3]), .tx_data(td[3]), .busy(bz[3]),
    .frame_done(fd[3]), .wr_err(we[3]), .byte_cnt(bc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Event counters, sampled 1 ns after each edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cur_start === 1'b1) start_cnt++;
      if (cur_werr === 1'b1) werr_cnt++;
    end
  end

  // UART model: capture the byte on tx_start, hold for 'lat' cycles, pulse tx_done.
  initial begin
    logic [7:0] hold;
    tx_done = 1'b0;
    forever begin
      if (cur_start === 1'b1) begin
        hold = cur_data;
        captured.push_back(hold);
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (i == 0 && cur_start === 1'b1) pulse_err++;
          if (cur_busy === 1'b1 && cur_data !== hold) stable_err++;
        end
        tx_done = 1'b1;
        last_done_edge = cyc + 1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  typedef struct packed {
    int          dut;
    int          n_wr;
    logic [63:0] d;        // first byte in bits 63:56
    int          exp_cnt;
    int          exp_err;
    int          exp_ntx;
    logic [15:0] exp_crc;
  } vec_t;

  vec_t tbl [5];

  // Bit-serial CRC-16/MODBUS reference (LSB-first feedback form).
  function automatic logic [15:0] crc_model(input logic [63:0] d, input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = d[63-8*i -: 8];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic s);
    wr_en = 1'b1; wr_data = d; send = s;
    @(posedge clk); #1;
    wr_en = 1'b0; send = 1'b0;
  endtask

  task automatic finish_frame(input int dut, input logic [63:0] d, input int npay,
                              input int ntx, input logic [15:0] crc, input int s0);
    bit         ok;
    logic [7:0] e;
    ok = 0;
    for (int t = 0; t < 20000; t++) begin
      if (cur_fd === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("frame_done_seen", int'(ok), 1);
    if (ok) chk("gap_cycles", (cyc + 1) - last_done_edge, gap_of[dut]);
    @(posedge clk); #1;
    chk("frame_done_width", int'(cur_fd), 0);
    chk("busy_after_gap", int'(cur_busy), 0);
    chk("byte_cnt_after_gap", int'(bcv[sel]), 0);
    chk("tx_count", captured.size(), ntx);
    chk("start_count", start_cnt - s0, ntx);
    for (int i = 0; i < ntx && i < captured.size(); i++) begin
      if (i < npay)       e = d[63-8*i -: 8];
      else if (i == npay) e = crc[7:0];
      else                e = crc[15:8];
      chk($sformatf("byte%0d", i), int'(captured[i]), int'(e));
    end
  endtask

  task automatic run_frame(input vec_t v);
    int s0, e0;
    sel = v.dut;
    @(posedge clk); #1;
    captured.delete();
    s0 = start_cnt;
    e0 = werr_cnt;
    for (int i = 0; i < v.n_wr; i++) wr(v.d[63-8*i -: 8], 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("byte_cnt_loaded", int'(bcv[sel]), v.exp_cnt);
    chk("wr_err_pulses", werr_cnt - e0, v.exp_err);
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    chk("busy_on_send", int'(cur_busy), 1);
    chk("tx_start_on_send", int'(cur_start), 1);
    finish_frame(v.dut, v.d, v.exp_cnt, v.exp_ntx, v.exp_crc, s0);
  endtask

  initial begin
    vec_t v;
    int   s0, e0;
    bit   ok;

    gap_of[0] = 16709; gap_of[1] = 385; gap_of[2] = 385; gap_of[3] = 385;
    tbl[0] = '{dut:0, n_wr:6, d:64'h0103_0000_0001_0000, exp_cnt:6, exp_err:0, exp_ntx:8, exp_crc:16'h0A84};
    tbl[1] = '{dut:1, n_wr:6, d:64'h0103_0000_000A_0000, exp_cnt:6, exp_err:0, exp_ntx:8, exp_crc:16'hCDC5};
    tbl[2] = '{dut:2, n_wr:5, d:64'h1122_3344_9900_0000, exp_cnt:4, exp_err:1, exp_ntx:6,
               exp_crc:crc_model(64'h1122_3344_0000_0000, 4)};
    tbl[3] = '{dut:3, n_wr:3, d:64'hAABB_CC00_0000_0000, exp_cnt:3, exp_err:0, exp_ntx:3, exp_crc:16'h0000};
    tbl[4] = '{dut:1, n_wr:8, d:64'h0102_0304_0506_0708, exp_cnt:8, exp_err:0, exp_ntx:10,
               exp_crc:crc_model(64'h0102_0304_0506_0708, 8)};

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0; sel = 0; lat = 2;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      sel = k; #1;
      chk("rst_tx_start", int'(cur_start), 0);
      chk("rst_busy", int'(cur_busy), 0);
      chk("rst_tx_data", int'(cur_data), 0);
      chk("rst_byte_cnt", int'(bcv[k]), 0);
    end
    sel = 0;
    chk("rst_frame_done", int'(cur_fd), 0);
    chk("rst_wr_err", int'(cur_werr), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Empty buffer: send is ignored.
    sel = 1;
    @(posedge clk); #1;
    s0 = start_cnt;
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    chk("empty_send_busy", int'(cur_busy), 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("empty_send_starts", start_cnt - s0, 0);

    // Write and send in the same cycle, plus a write dropped while busy.
    captured.delete();
    s0 = start_cnt;
    e0 = werr_cnt;
    wr(8'h55, 1'b1);
    chk("same_cycle_busy", int'(cur_busy), 1);
    chk("same_cycle_cnt", int'(bcv[sel]), 1);
    wr(8'h77, 1'b0);
    @(posedge clk); #1;
    chk("busy_write_err", werr_cnt - e0, 1);
    chk("busy_write_cnt", int'(bcv[sel]), 1);
    finish_frame(1, 64'h5500_0000_0000_0000, 1, 3, crc_model(64'h5500_0000_0000_0000, 1), s0);

    // Next frame starts right after frame_done; CRC must restart from 0xFFFF.
    captured.delete();
    s0 = start_cnt;
    wr(8'h02, 1'b0);
    wr(8'hB3, 1'b1);
    chk("back_to_back_busy", int'(cur_busy), 1);
    finish_frame(1, 64'h02B3_0000_0000_0000, 2, 4, crc_model(64'h02B3_0000_0000_0000, 2), s0);

    // Reset while byte 3 is in flight.
    lat = 30;
    captured.delete();
    for (int i = 0; i < 6; i++) wr(tbl[0].d[63-8*i -: 8], 1'b0);
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      if (captured.size() >= 3) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("abort_reached_byte3", int'(ok), 1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(cur_busy), 0);
    chk("abort_tx_start", int'(cur_start), 0);
    chk("abort_byte_cnt", int'(bcv[sel]), 0);
    chk("abort_tx_data", int'(cur_data), 0);
    s0 = start_cnt;
    repeat (60) begin @(posedge clk); #1; end
    chk("abort_no_more_starts", start_cnt - s0, 0);
    chk("abort_still_idle", int'(cur_busy), 0);
    lat = 2;
    v = tbl[0];
    v.dut = 1;
    run_frame(v);

    chk("tx_data_stable", stable_err, 0);
    chk("tx_start_one_cycle", pulse_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
